sdram_frame_fetcher: RTL and testbench
======================================

Name: sdram_frame_fetcher

Overview:
- Upstream neighbour of the VGA display controller. Runs in the SDRAM clock domain.
- Streams one IMG_WIDTH x IMG_HEIGHT frame of 16-bit pixels from SDRAM into the write side of the dual-clock pixel FIFO, one fixed-length burst at a time.
- Throttles on FIFO fill level.
- Restarts at the frame base address on every VGA vertical sync, so FIFO contents stay frame-aligned with the display scan.

Parameters:
- IMG_WIDTH, 320, pixels per line.
- IMG_HEIGHT, 240, lines per frame.
- BURST_LEN, 8, words per SDRAM read burst; power of 2; IMG_WIDTH*IMG_HEIGHT must be a multiple of it.
- ADDR_W, 24, SDRAM word-address width.
- BASE_ADDR, 0, word address of pixel (0,0).

Ports:
- clk_sdram  in  1  SDRAM-domain clock; sole clock of the block.
- rst  in  1  asynchronous, active-high reset.
- vga_vsync  in  1  VGA-domain vsync, active-low, asynchronous to clk_sdram.
- rd_req  out  1  burst read request.
- rd_addr  out  ADDR_W  burst start word address.
- rd_ack  in  1  request accepted, 1-cycle pulse.
- rd_data  in  16  read beat data.
- rd_data_valid  in  1  read beat valid.
- fifo_write_enable  out  1  FIFO write strobe.
- fifo_write_data  out  16  FIFO write data.
- fifo_full  in  1  FIFO write-side full.
- fifo_half_full  in  1  FIFO write-side at least half full.
- fifo_flush  out  1  1-cycle FIFO clear pulse.
- frame_done  out  1  high while the whole frame has been fetched.
- overflow  out  1  sticky error: beat arrived while FIFO was full.

Behaviour:
- Reset:
  - All outputs 0. State IDLE. pixel_count=0. beat_count=0. restart_pending=0.
  - Synchronizer flops reset to 1 (vsync inactive).
  - rst asserted mid-operation clears everything immediately, including a burst in flight. Any beats still arriving after release are ignored while IDLE.
- vsync handling:
  - 2-flop synchronizer, then falling-edge detect produces new_frame, a 1-cycle pulse 3 clk_sdram cycles after the input edge.
- States: IDLE, FLUSH, WAIT_ROOM, REQ, RECV, DRAIN, DONE.
- IDLE: no fetching. new_frame -> FLUSH.
- FLUSH:
  - fifo_flush=1 for exactly one cycle.
  - pixel_count<=0, restart_pending<=0.
  - -> WAIT_ROOM.
- WAIT_ROOM:
  - If pixel_count==IMG_WIDTH*IMG_HEIGHT: -> DONE.
  - Else if !fifo_half_full: -> REQ.
  - Else hold.
- REQ:
  - rd_req=1, with rd_addr=BASE_ADDR+pixel_count held stable until rd_ack.
  - rd_req drops in the cycle after rd_ack. No request is ever withdrawn.
  - On rd_ack: beat_count<=0. -> DRAIN if restart_pending, else RECV.
- RECV:
  - Each rd_data_valid cycle: fifo_write_data<=rd_data and fifo_write_enable<=1 on the next edge (1-cycle registered latency); beat_count++.
  - On the BURST_LEN-th beat: pixel_count+=BURST_LEN, -> WAIT_ROOM.
- DRAIN:
  - Counts the remaining beats of the outstanding burst without writing.
  - On the last beat: -> FLUSH.
- DONE: frame_done=1. new_frame -> FLUSH.
- new_frame in each state:
  - WAIT_ROOM or DONE: -> FLUSH next cycle.
  - REQ: set restart_pending; the burst is then drained.
  - RECV: -> DRAIN. The beat in the same cycle is counted but not written.
  - FLUSH or DRAIN: ignored; the restart is already under way.
- Overflow: a beat in RECV while fifo_full=1 is not written, still counts toward the burst, and sets overflow. overflow clears only on rst.
- Spurious beats: rd_data_valid in IDLE, FLUSH, WAIT_ROOM, REQ or DONE is ignored.
- Widths:
  - pixel_count is $clog2(IMG_WIDTH*IMG_HEIGHT+1) bits.
  - beat_count is $clog2(BURST_LEN) bits and wraps naturally.
  - Address sum is truncated to ADDR_W.
- Throughput: at most one burst outstanding. The FIFO must have depth >= 2*BURST_LEN, so a burst issued below half-full cannot overflow.

Decomposition:
- Package frame_fetch_pkg holds:
  - state enum fetch_state_t.
  - FRAME_PIXELS localparam function of IMG_WIDTH/IMG_HEIGHT.
  - Shared VGA timing constants (H/V visible, front porch, sync, back porch), reused by the display controller.
- One sub-module: vsync_edge_sync, holding the 2-flop synchronizer and falling-edge pulse generator (clk_sdram, rst, async_in, fall_pulse).

Test Plan:
- rst release, then vga_vsync 1->0 -> fifo_flush single pulse 3-4 cycles later; then rd_req=1, rd_addr=0.
- IMG_WIDTH=16, IMG_HEIGHT=2, BURST_LEN=8, rd_ack immediate, 8 beats per burst, data=address -> rd_addr sequence 0, 8, 16, 24; 32 FIFO writes carrying data 0..31 in order; frame_done=1 after the 32nd write; no further rd_req.
- fifo_half_full held at 1 -> no rd_req for 100 cycles; drop it to 0 -> rd_req rises within 2 cycles.
- rd_ack delayed 10 cycles -> rd_req and rd_addr stable for all 10 cycles; rd_req low the cycle after rd_ack.
- vsync falls after 3 beats of the burst at rd_addr=8 -> remaining 5 beats produce no writes; fifo_flush pulses once; next rd_req has rd_addr=0.
- fifo_full=1 during beat 4 of a burst -> that beat not written, overflow=1 and stays 1 through a new frame; rst asserted mid-RECV -> all outputs 0 immediately, overflow cleared.

Source files
------------

// File: rtl/sdram_frame_fetcher_pkg.sv
// Shared types and constants for the SDRAM frame fetcher and the VGA display path.
package frame_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WAIT_ROOM,
        ST_REQ,
        ST_RECV,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    // Pixel count of one frame; used to size counters and detect frame end.
    function automatic int frame_pixels(input int img_width, input int img_height);
        return img_width * img_height;
    endfunction

    localparam int DEFAULT_IMG_WIDTH  = 320;
    localparam int DEFAULT_IMG_HEIGHT = 240;
    localparam int FRAME_PIXELS       = frame_pixels(DEFAULT_IMG_WIDTH, DEFAULT_IMG_HEIGHT);

    // 640x480@60 timing, shared with the display controller.
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

endpackage

// File: rtl/sdram_frame_fetcher_vsync_edge_sync.sv
// Brings the VGA-domain vsync into the SDRAM domain and emits a one-cycle
// pulse on its falling (active) edge.
module vsync_edge_sync (
    input  logic clk_sdram,
    input  logic rst,
    input  logic async_in,
    output logic fall_pulse
);

    // [0],[1] are the metastability stages; [2] is the previous synced value.
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the input through the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    // Chain resets to the inactive (high) level so reset never looks like an edge.
    always_ff @(posedge clk_sdram or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign fall_pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/sdram_frame_fetcher.sv
// Streams one frame from SDRAM into the pixel FIFO in fixed bursts,
// throttled on FIFO level and restarted on every VGA vsync.
module sdram_frame_fetcher
    import frame_fetch_pkg::*;
#(
    parameter int          IMG_WIDTH  = 320,
    parameter int          IMG_HEIGHT = 240,
    parameter int          BURST_LEN  = 8,
    parameter int          ADDR_W     = 24,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk_sdram,
    input  logic              rst,
    input  logic              vga_vsync,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [15:0]       rd_data,
    input  logic              rd_data_valid,
    output logic              fifo_write_enable,
    output logic [15:0]       fifo_write_data,
    input  logic              fifo_full,
    input  logic              fifo_half_full,
    output logic              fifo_flush,
    output logic              frame_done,
    output logic              overflow
);

    localparam int FRAME_PX = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int PIX_W    = $clog2(FRAME_PX + 1);
    localparam int BEAT_W   = $clog2(BURST_LEN);

    fetch_state_t      state_q, state_d;
    logic [PIX_W-1:0]  pixel_count_q, pixel_count_d;
    logic [BEAT_W-1:0] beat_count_q, beat_count_d;
    logic              restart_pending_q, restart_pending_d;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              overflow_q, overflow_d;
    logic              new_frame;
    logic              last_beat;

    vsync_edge_sync u_vsync_sync (
        .clk_sdram (clk_sdram),
        .rst       (rst),
        .async_in  (vga_vsync),
        .fall_pulse(new_frame)
    );

    assign last_beat = (beat_count_q == BEAT_W'(BURST_LEN - 1));

    // Next-state and datapath updates; a restart always funnels through FLUSH
    // so the FIFO never holds pixels from two different frame starts.
    always_comb begin
        state_d           = state_q;
        pixel_count_d     = pixel_count_q;
        beat_count_d      = beat_count_q;
        restart_pending_d = restart_pending_q;
        wr_en_d           = 1'b0;
        wr_data_d         = wr_data_q;
        overflow_d        = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (new_frame) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                pixel_count_d     = '0;
                restart_pending_d = 1'b0;
                state_d           = ST_WAIT_ROOM;
            end
            ST_WAIT_ROOM: begin
                if (new_frame)                               state_d = ST_FLUSH;
                else if (pixel_count_q == PIX_W'(FRAME_PX)) state_d = ST_DONE;
                else if (!fifo_half_full)                    state_d = ST_REQ;
            end
            ST_REQ: begin
                // A request cannot be withdrawn, so a restart here waits for
                // the burst and discards it.
                if (new_frame) restart_pending_d = 1'b1;
                if (rd_ack) begin
                    beat_count_d = '0;
                    state_d      = restart_pending_d ? ST_DRAIN : ST_RECV;
                end
            end
            ST_RECV: begin
                if (rd_data_valid) begin
                    beat_count_d = beat_count_q + BEAT_W'(1);
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else if (!new_frame) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = rd_data;
                    end
                end
                if (rd_data_valid && last_beat) begin
                    if (new_frame) begin
                        state_d = ST_FLUSH;
                    end else begin
                        pixel_count_d = pixel_count_q + PIX_W'(BURST_LEN);
                        state_d       = ST_WAIT_ROOM;
                    end
                end else if (new_frame) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_data_valid) begin
                    beat_count_d = beat_count_q + BEAT_W'(1);
                    if (last_beat) state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                if (new_frame) state_d = ST_FLUSH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered FIFO write port; reset aborts any burst.
    always_ff @(posedge clk_sdram or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            pixel_count_q     <= '0;
            beat_count_q      <= '0;
            restart_pending_q <= 1'b0;
            wr_en_q           <= 1'b0;
            wr_data_q         <= '0;
            overflow_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            pixel_count_q     <= pixel_count_d;
            beat_count_q      <= beat_count_d;
            restart_pending_q <= restart_pending_d;
            wr_en_q           <= wr_en_d;
            wr_data_q         <= wr_data_d;
            overflow_q        <= overflow_d;
        end
    end

    assign rd_req            = (state_q == ST_REQ);
    assign rd_addr           = rd_req ? (ADDR_W'(BASE_ADDR) + ADDR_W'(pixel_count_q)) : '0;
    assign fifo_flush        = (state_q == ST_FLUSH);
    assign frame_done        = (state_q == ST_DONE);
    assign fifo_write_enable = wr_en_q;
    assign fifo_write_data   = wr_data_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// Bench for sdram_frame_fetcher: SDRAM responder, FIFO-content model and
// table-driven plus randomized frame runs.
module tb_sdram_frame_fetcher;

    localparam int IW     = 16;
    localparam int IH     = 2;
    localparam int BL     = 8;
    localparam int AW     = 24;
    localparam int BASE   = 0;
    localparam int NPIX   = IW * IH;
    localparam int NBURST = NPIX / BL;

    logic          clk_sdram = 1'b0;
    logic          rst = 1'b1;
    logic          vga_vsync = 1'b1;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack = 1'b0;
    logic [15:0]   rd_data = '0;
    logic          rd_data_valid = 1'b0;
    logic          fifo_write_enable;
    logic [15:0]   fifo_write_data;
    logic          fifo_full = 1'b0;
    logic          fifo_half_full;
    logic          fifo_flush;
    logic          frame_done;
    logic          overflow;

    always #5 clk_sdram = ~clk_sdram;

    sdram_frame_fetcher #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .BURST_LEN (BL),
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_sdram        (clk_sdram),
        .rst              (rst),
        .vga_vsync        (vga_vsync),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .fifo_write_enable(fifo_write_enable),
        .fifo_write_data  (fifo_write_data),
        .fifo_full        (fifo_full),
        .fifo_half_full   (fifo_half_full),
        .fifo_flush       (fifo_flush),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responder / environment knobs
    int          ack_delay = 0;
    int          gap_max = 0;
    logic [15:0] key = '0;
    bit          stall_en = 0;
    int          stall_addr = 0;
    int          stall_beat = 0;
    int          stall_cycles = 20;
    bit          stalled = 0;
    bit          full_en = 0;
    int          full_addr = 0;
    int          full_beat = 0;
    bit          hf_force = 0;
    bit          hf_rand = 0;
    logic        hf_rnd = 1'b0;
    int          held_err = 0;
    int          drop_err = 0;

    assign fifo_half_full = hf_force | (hf_rand & hf_rnd);

    always @(negedge clk_sdram) hf_rnd <= ($urandom_range(0, 2) == 0);

    // SDRAM model: word at address a reads as a ^ key.
    function automatic logic [15:0] exp_pix(input int p);
        return 16'(BASE + p) ^ key;
    endfunction

    initial begin
        int a;
        int g;
        forever begin
            @(negedge clk_sdram);
            if (rd_req && !rst) begin
                a = int'(rd_addr);
                for (int d = 0; d < ack_delay; d++) begin
                    if (!rd_req || int'(rd_addr) != a) held_err++;
                    @(negedge clk_sdram);
                end
                if (!rd_req || int'(rd_addr) != a) held_err++;
                rd_ack = 1'b1;
                @(negedge clk_sdram);
                rd_ack = 1'b0;
                if (rd_req) drop_err++;
                for (int b = 0; b < BL; b++) begin
                    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
                    repeat (g) @(negedge clk_sdram);
                    if (stall_en && a == stall_addr && b == stall_beat) begin
                        stalled = 1;
                        repeat (stall_cycles) @(negedge clk_sdram);
                        stalled = 0;
                    end
                    rd_data_valid = 1'b1;
                    rd_data       = 16'(a + b) ^ key;
                    fifo_full     = full_en && a == full_addr && b == full_beat;
                    @(negedge clk_sdram);
                    rd_data_valid = 1'b0;
                    fifo_full     = 1'b0;
                end
            end
        end
    end

    // FIFO-content model: flush empties it, writes append.
    logic [15:0]   fifo_q[$];
    int            req_q[$];
    int            wr_total = 0;
    int            req_total = 0;
    int            flush_total = 0;
    int            flush_wr_total = 0;
    int            stab_err = 0;
    int            dbl_flush = 0;
    logic          prev_req = 1'b0;
    logic          prev_flush = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk_sdram) begin
        if (fifo_flush) begin
            fifo_q.delete();
            req_q.delete();
            flush_total    <= flush_total + 1;
            flush_wr_total <= wr_total;
            if (prev_flush) dbl_flush <= dbl_flush + 1;
        end
        if (fifo_write_enable) begin
            fifo_q.push_back(fifo_write_data);
            wr_total <= wr_total + 1;
        end
        if (rd_req && !prev_req) begin
            req_q.push_back(int'(rd_addr));
            req_total <= req_total + 1;
        end
        if (rd_req && prev_req && rd_addr != prev_addr) stab_err <= stab_err + 1;
        prev_req   <= rd_req;
        prev_flush <= fifo_flush;
        prev_addr  <= rd_addr;
    end

    task automatic pulse_vsync();
        vga_vsync = 1'b0;
        repeat (4) @(negedge clk_sdram);
        vga_vsync = 1'b1;
        repeat (2) @(negedge clk_sdram);
    endtask

    task automatic start_frame(input string tag);
        int f0;
        f0 = flush_total;
        pulse_vsync();
        check({tag, "_flush_once"}, flush_total - f0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sdram);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done_reached"}, ok, 1);
    endtask

    task automatic wait_stalled(input string tag);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_sdram);
            if (stalled) break;
        end
        check({tag, "_stall_reached"}, stalled, 1);
        stall_en = 0;
    endtask

    // Compares FIFO contents with the frame (optionally minus one dropped pixel).
    task automatic verify_frame(input string tag, input int skip);
        int bad;
        int idx;
        int rt;
        bad = 0;
        idx = 0;
        check({tag, "_words"}, fifo_q.size(), (skip >= 0) ? NPIX - 1 : NPIX);
        for (int p = 0; p < NPIX; p++) begin
            if (p != skip) begin
                if (idx >= fifo_q.size() || fifo_q[idx] !== exp_pix(p)) bad++;
                idx++;
            end
        end
        check({tag, "_data_bad"}, bad, 0);
        bad = 0;
        for (int k = 0; k < NBURST; k++)
            if (k >= req_q.size() || req_q[k] != BASE + k * BL) bad++;
        check({tag, "_req_count"}, req_q.size(), NBURST);
        check({tag, "_req_addr_bad"}, bad, 0);
        rt = req_total;
        repeat (20) @(negedge clk_sdram);
        check({tag, "_no_extra_req"}, req_total - rt, 0);
        check({tag, "_done_held"}, frame_done, 1);
    endtask

    typedef struct {
        int          delay;
        int          gap;
        logic [15:0] k;
        bit          hf;
        int          exp_words;
        int          exp_bursts;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat;
        int w0;
        int f0;
        int r0;
        string tag;

        vecs[0] = '{0,  0, 16'h0000, 1'b0, NPIX, NBURST};
        vecs[1] = '{10, 0, 16'h00ff, 1'b0, NPIX, NBURST};
        vecs[2] = '{2,  3, 16'ha5a5, 1'b0, NPIX, NBURST};
        vecs[3] = '{0,  1, 16'h1234, 1'b1, NPIX, NBURST};

        // Reset state
        repeat (3) @(negedge clk_sdram);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wen", fifo_write_enable, 0);
        check("rst_wdata", fifo_write_data, 0);
        check("rst_flush", fifo_flush, 0);
        check("rst_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk_sdram);
        check("idle_no_req", req_total, 0);
        check("idle_no_flush", flush_total, 0);

        // First vsync: flush latency, single pulse, first request at base
        vga_vsync = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_sdram);
            if (fifo_flush) begin
                lat = i;
                break;
            end
        end
        check("flush_latency_3_to_4", (lat >= 3 && lat <= 4), 1);
        @(negedge clk_sdram);
        check("flush_single_cycle", fifo_flush, 0);
        for (int i = 0; i < 10; i++) begin
            if (rd_req) break;
            @(negedge clk_sdram);
        end
        check("first_req", rd_req, 1);
        check("first_addr", rd_addr, BASE);
        vga_vsync = 1'b1;
        wait_done("t1");
        verify_frame("t1", -1);

        // Table-driven frame runs
        for (int v = 0; v < 4; v++) begin
            tag       = $sformatf("vec%0d", v);
            ack_delay = vecs[v].delay;
            gap_max   = vecs[v].gap;
            key       = vecs[v].k;
            hf_rand   = vecs[v].hf;
            held_err  = 0;
            drop_err  = 0;
            start_frame(tag);
            wait_done(tag);
            check({tag, "_words_tbl"}, fifo_q.size(), vecs[v].exp_words);
            check({tag, "_bursts_tbl"}, req_q.size(), vecs[v].exp_bursts);
            check({tag, "_req_held"}, held_err, 0);
            check({tag, "_req_drop"}, drop_err, 0);
            verify_frame(tag, -1);
        end
        ack_delay = 0;
        gap_max   = 0;
        key       = '0;
        hf_rand   = 0;

        // Half-full throttling
        hf_force = 1;
        start_frame("hf");
        r0 = req_total;
        repeat (100) @(negedge clk_sdram);
        check("hf_no_req", req_total - r0, 0);
        hf_force = 0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_sdram);
            if (rd_req) begin
                lat = i;
                break;
            end
        end
        check("hf_release_req", (lat >= 1 && lat <= 2), 1);
        wait_done("hf");
        verify_frame("hf", -1);

        // vsync after 3 beats of the burst at address 8
        stall_en   = 1;
        stall_addr = 8;
        stall_beat = 3;
        start_frame("abort");
        wait_stalled("abort");
        repeat (2) @(negedge clk_sdram);
        w0 = wr_total;
        check("abort_pre_words", fifo_q.size(), 11);
        f0 = flush_total;
        pulse_vsync();
        for (int i = 0; i < 100; i++) begin
            if (flush_total != f0) break;
            @(negedge clk_sdram);
        end
        repeat (3) @(negedge clk_sdram);
        check("abort_one_flush", flush_total - f0, 1);
        check("abort_no_writes", flush_wr_total - w0, 0);
        wait_done("abort");
        verify_frame("abort", -1);

        // FIFO full on beat 4 of the burst at address 16
        full_en   = 1;
        full_addr = 16;
        full_beat = 3;
        start_frame("ovf");
        wait_done("ovf");
        full_en = 0;
        verify_frame("ovf", 19);
        check("ovf_set", overflow, 1);
        start_frame("ovf2");
        wait_done("ovf2");
        verify_frame("ovf2", -1);
        check("ovf_sticky", overflow, 1);

        // Reset in the middle of a burst
        stall_en   = 1;
        stall_addr = 8;
        stall_beat = 3;
        start_frame("mrst");
        wait_stalled("mrst");
        @(negedge clk_sdram);
        rst = 1'b1;
        #1;
        check("mrst_rd_req", rd_req, 0);
        check("mrst_rd_addr", rd_addr, 0);
        check("mrst_wen", fifo_write_enable, 0);
        check("mrst_wdata", fifo_write_data, 0);
        check("mrst_flush", fifo_flush, 0);
        check("mrst_done", frame_done, 0);
        check("mrst_overflow", overflow, 0);
        @(negedge clk_sdram);
        rst = 1'b0;
        w0 = wr_total;
        r0 = req_total;
        repeat (40) @(negedge clk_sdram);
        check("mrst_beats_ignored", wr_total - w0, 0);
        check("mrst_no_req", req_total - r0, 0);
        check("mrst_idle_not_done", frame_done, 0);
        start_frame("mrst_rec");
        wait_done("mrst_rec");
        verify_frame("mrst_rec", -1);

        // Randomized runs, some with a restart at a random moment
        for (int it = 0; it < 6; it++) begin
            tag       = $sformatf("rnd%0d", it);
            ack_delay = $urandom_range(0, 4);
            gap_max   = $urandom_range(0, 2);
            key       = 16'($urandom);
            hf_rand   = ($urandom_range(0, 1) == 1);
            held_err  = 0;
            drop_err  = 0;
            start_frame(tag);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 50)) @(negedge clk_sdram);
                pulse_vsync();
                repeat (2) @(negedge clk_sdram);
            end
            wait_done(tag);
            check({tag, "_req_held"}, held_err, 0);
            check({tag, "_req_drop"}, drop_err, 0);
            verify_frame(tag, -1);
        end
        hf_rand = 0;

        check("addr_stable_while_req", stab_err, 0);
        check("no_double_flush", dbl_flush, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
